// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the fetch stage: instruction field positions,
// instruction width and the fetch FSM state encoding.
package fetch_unit_pkg;

    localparam int ILEN    = 16;
    localparam int OPC_MSB = 15;
    localparam int OPC_LSB = 12;
    localparam int M_BIT   = 11;
    localparam int RD_MSB  = 10;
    localparam int RD_LSB  = 8;
    localparam int RS1_MSB = 7;
    localparam int RS1_LSB = 5;
    localparam int IMM_MSB = 4;
    localparam int IMM_LSB = 0;

    typedef enum logic [1:0] {
        FS_IDLE = 2'd0,
        FS_REQ  = 2'd1,
        FS_HOLD = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory request/acknowledge bus between the fetch stage and imem.
// Handshake: master raises imem_req with imem_addr and holds both stable until
// the slave pulses imem_ack for one cycle with imem_rdata valid in that cycle.
interface fetch_unit_if
    import fetch_unit_pkg::*;
#(
    parameter int PC_W = 16
) ();
    logic            imem_req;
    logic [PC_W-1:0] imem_addr;
    logic            imem_ack;
    logic [ILEN-1:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );
endinterface

// File: rtl/fetch_unit.sv
// Fetch stage: owns the PC, fetches one word per request from imem into the IR
// and exposes the IR as decoded fields plus the address it came from.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int              PC_W     = 16,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            fetch_en,
    input  logic            pc_load,
    input  logic [PC_W-1:0] pc_next,
    fetch_unit_if.master    imem,
    output logic            ir_valid,
    input  logic            ir_consume,
    output logic [3:0]      opcode,
    output logic            m,
    output logic [2:0]      rd,
    output logic [2:0]      rs1,
    output logic [4:0]      imm,
    output logic [PC_W-1:0] pc_of_ir,
    output logic            busy,
    output fetch_state_e    dbg_state
);

    fetch_state_e    state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [PC_W-1:0] addr_q, addr_d;
    logic [PC_W-1:0] pc_of_ir_q, pc_of_ir_d;
    logic [ILEN-1:0] ir_q, ir_d;
    logic            squash_q, squash_d;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        ir_d       = ir_q;
        pc_of_ir_d = pc_of_ir_q;
        squash_d   = squash_q;
        case (state_q)
            FS_IDLE: begin
                if (pc_load) pc_d = pc_next;
                if (fetch_en) state_d = FS_REQ;
            end
            FS_REQ: begin
                if (imem.imem_ack) begin
                    // A redirect seen during or at the end of the request
                    // throws the word away and restarts at the current PC.
                    if (pc_load || squash_q) begin
                        pc_d     = pc_load ? pc_next : pc_q;
                        squash_d = 1'b0;
                    end else begin
                        ir_d       = imem.imem_rdata;
                        pc_of_ir_d = pc_q;
                        pc_d       = pc_q + 1'b1;
                        state_d    = FS_HOLD;
                    end
                end else if (pc_load) begin
                    pc_d     = pc_next;
                    squash_d = 1'b1;
                end
            end
            FS_HOLD: begin
                if (pc_load) begin
                    pc_d    = pc_next;
                    state_d = FS_IDLE;
                end else if (ir_consume) begin
                    state_d = fetch_en ? FS_REQ : FS_IDLE;
                end
            end
            default: state_d = FS_IDLE;
        endcase
        // The bus address is frozen for the whole request, even across a redirect.
        addr_d = (state_q == FS_REQ && !imem.imem_ack) ? addr_q : pc_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= FS_IDLE;
            pc_q       <= RESET_PC;
            addr_q     <= RESET_PC;
            pc_of_ir_q <= '0;
            ir_q       <= '0;
            squash_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            addr_q     <= addr_d;
            pc_of_ir_q <= pc_of_ir_d;
            ir_q       <= ir_d;
            squash_q   <= squash_d;
        end
    end

    assign imem.imem_req  = (state_q == FS_REQ);
    assign imem.imem_addr = addr_q;
    assign busy           = (state_q == FS_REQ);
    assign ir_valid       = (state_q == FS_HOLD);
    assign dbg_state      = state_q;

    assign opcode   = ir_q[OPC_MSB:OPC_LSB];
    assign m        = ir_q[M_BIT];
    assign rd       = ir_q[RD_MSB:RD_LSB];
    assign rs1      = ir_q[RS1_MSB:RS1_LSB];
    assign imm      = ir_q[IMM_MSB:IMM_LSB];
    assign pc_of_ir = pc_of_ir_q;

endmodule
